// File: rtl/seven_seg_mux.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each digit gets an all-off guard slot followed by a drive slot. Digit values
// and blanking are latched once per frame so a frame never mixes old and new data.
module seven_seg_mux #(
   parameter int unsigned NUM_DIGITS   = 2,
   parameter int unsigned DWELL_CYCLES = 24000,
   parameter int unsigned GUARD_CYCLES = 240
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned MaxCycles = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);
   localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
   localparam logic [CntW-1:0] GuardLast = CntW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {StGuard, StDrive} state_e;

   // The slot that opens a frame: guard of digit 0, or its drive slot when there is no guard.
   localparam state_e SlotStart = (GUARD_CYCLES > 0) ? StGuard : StDrive;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
   logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
   logic                    load_pending_q;
   logic                    capture;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_d;
   logic                    frame_done_d;

   // Active-low {g,f,e,d,c,b,a} hex font.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h18;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Slot sequencing: guard then drive per digit, wrapping the digit index after the last one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      unique case (state_q)
         StGuard: begin
            if (GUARD_CYCLES == 0 || cnt_q == GuardLast) begin
               state_d = StDrive;
               cnt_d   = '0;
            end
         end
         StDrive: begin
            if (cnt_q == DwellLast) begin
               cnt_d = '0;
               idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
               if (GUARD_CYCLES > 0) state_d = StGuard;
            end
         end
         default: begin
            state_d = StGuard;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Frame capture on the edge opening digit 0's first slot; the first edge out of reset
   // also captures because reset itself already opened that slot with zeroed shadows.
   always_comb begin
      capture         = load_pending_q ||
                        (idx_d == '0 && cnt_d == '0 && state_d == SlotStart);
      shadow_digits_d = capture ? digits_in : shadow_digits_q;
      shadow_blank_d  = capture ? blank_in  : shadow_blank_q;
   end

   // Output decode from next state so outputs change on the same edge as the FSM.
   always_comb begin
      seg_d        = 7'h7F;
      an_d         = '1;
      frame_done_d = 1'b0;
      if (state_d == StDrive) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IdxW'(i) && !shadow_blank_d[i]) begin
               an_d[i] = 1'b0;
               seg_d   = decode(shadow_digits_d[4*i +: 4]);
            end
         end
         frame_done_d = (cnt_d == DwellLast) && (idx_d == IdxLast);
      end
   end

   // State, shadow and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StGuard;
         cnt_q           <= '0;
         idx_q           <= '0;
         shadow_digits_q <= '0;
         shadow_blank_q  <= '0;
         load_pending_q  <= 1'b1;
         seg             <= 7'h7F;
         an              <= '1;
         frame_done      <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         idx_q           <= idx_d;
         shadow_digits_q <= shadow_digits_d;
         shadow_blank_q  <= shadow_blank_d;
         load_pending_q  <= 1'b0;
         seg             <= seg_d;
         an              <= an_d;
         frame_done      <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux: a 2-digit instance (dwell 4, guard 1)
// driven by a frame vector table, and a 1-digit no-guard instance for the decode sweep.
module tb_seven_seg_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, reset_b;
   logic [7:0] digits_a;
   logic [1:0] blank_a;
   logic [6:0] seg_a;
   logic [1:0] an_a;
   logic       fd_a;
   logic [3:0] digits_b;
   logic [0:0] blank_b;
   logic [6:0] seg_b;
   logic [0:0] an_b;
   logic       fd_b;

   seven_seg_mux #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .GUARD_CYCLES(1)) dut_a (
      .clk(clk), .reset(reset_a), .digits_in(digits_a), .blank_in(blank_a),
      .seg(seg_a), .an(an_a), .frame_done(fd_a)
   );

   seven_seg_mux #(.NUM_DIGITS(1), .DWELL_CYCLES(4), .GUARD_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset_b), .digits_in(digits_b), .blank_in(blank_b),
      .seg(seg_b), .an(an_b), .frame_done(fd_b)
   );

   typedef struct packed {
      logic [6:0] seg;
      logic [1:0] an;
      logic       fd;
   } out_t;

   typedef struct packed {
      logic [7:0] digits;
      logic [1:0] blank;
      logic [6:0] seg0;
      logic [1:0] an0;
      logic [6:0] seg1;
      logic [1:0] an1;
   } vec_t;

   localparam out_t Dark = '{seg: 7'h7F, an: 2'b11, fd: 1'b0};

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   out_t sb_a[$];
   out_t sb_b[$];
   int   errors = 0;
   int   checks = 0;
   vec_t vec [7];

   task automatic cmp_a(input string name);
      out_t want, got;
      want = sb_a.pop_front();
      got  = {seg_a, an_a, fd_a};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                  name, got.seg, got.an, got.fd, want.seg, want.an, want.fd);
      end
   endtask

   task automatic cmp_b(input string name);
      out_t want, got;
      want = sb_b.pop_front();
      got  = {seg_b, 1'b1, an_b, fd_b};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                  name, got.seg, got.an[0], got.fd, want.seg, want.an[0], want.fd);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle_a(input out_t e, input string name);
      sb_a.push_back(e);
      tick();
      cmp_a(name);
   endtask

   task automatic cycle_b(input out_t e, input string name);
      sb_b.push_back(e);
      tick();
      cmp_b(name);
   endtask

   // Frame position k: 0 guard d0, 1..4 drive d0, 5 guard d1, 6..9 drive d1 (frame_done at 9).
   function automatic out_t frame_exp(input int k, input vec_t v);
      out_t e;
      if (k == 0 || k == 5) e = Dark;
      else if (k <= 4) e = '{seg: v.seg0, an: v.an0, fd: 1'b0};
      else e = '{seg: v.seg1, an: v.an1, fd: (k == 9)};
      return e;
   endfunction

   task automatic run_frame(input int k0, input int k1, input vec_t cur, input vec_t nxt,
                            input int change_at, input string tag);
      for (int k = k0; k <= k1; k++) begin
         cycle_a(frame_exp(k, cur), $sformatf("%s k=%0d", tag, k));
         if (k == change_at) begin
            digits_a = nxt.digits;
            blank_a  = nxt.blank;
         end
      end
   endtask

   initial begin
      vec[0] = '{digits: 8'h3A, blank: 2'b00, seg0: 7'h08, an0: 2'b10, seg1: 7'h30, an1: 2'b01};
      vec[1] = '{digits: 8'hF0, blank: 2'b00, seg0: 7'h40, an0: 2'b10, seg1: 7'h0E, an1: 2'b01};
      vec[2] = '{digits: 8'h3A, blank: 2'b10, seg0: 7'h08, an0: 2'b10, seg1: 7'h7F, an1: 2'b11};
      vec[3] = '{digits: 8'h5C, blank: 2'b01, seg0: 7'h7F, an0: 2'b11, seg1: 7'h12, an1: 2'b01};
      vec[4] = '{digits: 8'h7B, blank: 2'b00, seg0: 7'h03, an0: 2'b10, seg1: 7'h78, an1: 2'b01};
      vec[5] = '{digits: 8'h96, blank: 2'b11, seg0: 7'h7F, an0: 2'b11, seg1: 7'h7F, an1: 2'b11};
      vec[6] = vec[0];

      reset_a  = 1'b1;
      reset_b  = 1'b1;
      digits_a = vec[0].digits;
      blank_a  = vec[0].blank;
      digits_b = 4'h0;
      blank_b  = 1'b0;

      // Reset held for 3 cycles on both instances.
      for (int i = 0; i < 3; i++) begin
         sb_a.push_back(Dark);
         sb_b.push_back(Dark);
         tick();
         cmp_a($sformatf("reset_a %0d", i));
         cmp_b($sformatf("reset_b %0d", i));
      end

      // Release: the guard slot is already underway, so the first edge starts drive of digit 0.
      reset_a = 1'b0;
      run_frame(1, 9, vec[0], vec[1], 2, "frame0");
      // Inputs change mid digit-0 drive; the change shows only from the next frame.
      for (int v = 1; v < 7; v++)
         run_frame(0, 9, vec[v], vec[(v < 6) ? v + 1 : 6], 2, $sformatf("frame%0d", v));

      // Reset pulse during digit-1 drive, then restart with a fresh capture of F0.
      run_frame(0, 7, vec[6], vec[6], -1, "pre_reset");
      digits_a = vec[1].digits;
      blank_a  = vec[1].blank;
      reset_a  = 1'b1;
      cycle_a(Dark, "mid_drive_reset");
      reset_a = 1'b0;
      run_frame(1, 9, vec[1], vec[1], -1, "restart");
      run_frame(0, 4, vec[1], vec[1], -1, "restart2");

      // Single digit, no guard: continuous drive, frame_done every 4 cycles, decode sweep.
      reset_b = 1'b0;
      for (int n = 0; n < 17; n++) begin
         for (int c = 0; c < 4; c++) begin
            out_t e;
            if (n < 16) e = '{seg: font[n], an: 2'b10, fd: (c == 3)};
            else e = '{seg: 7'h7F, an: 2'b11, fd: (c == 3)};
            cycle_b(e, $sformatf("single n=%0d c=%0d", n, c));
            if (c == 1) begin
               if (n < 15) digits_b = 4'(n + 1);
               else blank_b = 1'b1;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
